sha_dispatch_sched: RTL and testbench

Scheduler that shares one 16-word message image and a nonce counter across `NUM_CORES` sha256 cores. It time-multiplexes a single serial text bus to load each idle core with its own nonce. It watches every core for completion and tests the top 32 digest bits against a leading-zero target. It sits between the Nios II custom-instruction front end, which drives the cfg/status ports, and the array of sha256 cores.

---
 rtl/sha_dispatch_sched_if.sv | 24 ++
 rtl/sha_dispatch_sched.sv | 110 +++++++++++
 tb/tb_sha_dispatch_sched.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sha_dispatch_sched_if.sv
// sha_dispatch_sched_if: cfg/status bus from the front end plus the shared text/cmd bus and per-core status
interface sha_dispatch_sched_if #(parameter int NUM_CORES = 2);
  logic                   cfg_we;
  logic [4:0]             cfg_addr;
  logic [31:0]            cfg_wdata;
  logic                   busy;
  logic                   hit;
  logic [31:0]            hit_nonce;
  logic [31:0]            nonce_cur;
  logic                   wrapped;
  logic [31:0]            core_text;
  logic [2:0]             core_cmd;
  logic [NUM_CORES-1:0]   core_cmd_w;
  logic [NUM_CORES-1:0]   core_busy;
  logic [32*NUM_CORES-1:0] core_dig_hi;
  modport master (
    output cfg_we, cfg_addr, cfg_wdata, core_busy, core_dig_hi,
    input  busy, hit, hit_nonce, nonce_cur, wrapped, core_text, core_cmd, core_cmd_w
  );
  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, core_busy, core_dig_hi,
    output busy, hit, hit_nonce, nonce_cur, wrapped, core_text, core_cmd, core_cmd_w
  );
endinterface

// File: rtl/sha_dispatch_sched.sv
// sha_dispatch_sched: dispatches nonces to NUM_CORES sha256 cores over one text bus and flags leading-zero digests (ports: clk, reset, bus = cfg/status + core bus)
module sha_dispatch_sched #(parameter int NUM_CORES = 2) (
  input logic clk,
  input logic reset,
  sha_dispatch_sched_if.slave bus
);
  localparam int IW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  typedef enum logic [2:0] {IDLE, SELECT, LOAD, RUNWAIT, DRAIN, HIT} state_t;
  state_t state, next;
  logic [31:0] start_nonce, mask, win_nonce;
  logic [31:0] msg [16];
  logic [31:0] nonce_k [NUM_CORES];
  logic [5:0] zbits;
  logic [4:0] beat;
  logic [IW-1:0] sel, rr, pick;
  logic [NUM_CORES-1:0] inflight, seen_busy, done, qual;
  logic found, stop_pend, go, stop, cfg_ok, hit_take, load_end;
  assign mask = 32'hFFFFFFFF >> zbits;
  assign cfg_ok = state == IDLE || state == HIT;
  assign go = bus.cfg_we && bus.cfg_addr == 5'd17 && bus.cfg_wdata[0];
  assign stop = bus.cfg_we && bus.cfg_addr == 5'd17 && bus.cfg_wdata[1];
  assign done = inflight & seen_busy & ~bus.core_busy;
  assign hit_take = |qual && !cfg_ok;
  assign load_end = state == LOAD && beat == 5'd16;
  assign bus.busy = !cfg_ok;
  assign bus.core_cmd_w = state == LOAD && beat == 5'd0 ? NUM_CORES'(1) << sel : '0;
  assign bus.core_cmd = state == LOAD && beat == 5'd0 ? 3'b010 : 3'b000;
  assign bus.core_text = state != LOAD || beat == 5'd0 ? 32'd0 :
                         beat == 5'd1 ? bus.nonce_cur : msg[4'(beat - 5'd1)];
  // Both loops run high-to-low so the lowest index / nearest round-robin slot wins.
  always_comb begin
    qual = '0;
    win_nonce = '0;
    found = 1'b0;
    pick = rr;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      qual[k] = done[k] && ((mask | bus.core_dig_hi[32*k +: 32]) == mask);
      if (qual[k]) win_nonce = nonce_k[k];
    end
    for (int i = NUM_CORES - 1; i >= 0; i--)
      if (!inflight[(int'(rr) + i) % NUM_CORES]) begin
        found = 1'b1;
        pick = IW'((int'(rr) + i) % NUM_CORES);
      end
  end
  always_comb begin
    next = state;
    case (state)
      IDLE, HIT: next = go ? SELECT : state;
      SELECT:    next = hit_take ? HIT : stop ? DRAIN : found ? LOAD : RUNWAIT;
      LOAD:      next = hit_take ? HIT : !load_end ? LOAD : (stop || stop_pend) ? DRAIN : SELECT;
      RUNWAIT:   next = hit_take ? HIT : stop ? DRAIN : !(&inflight) ? SELECT : RUNWAIT;
      DRAIN:     next = hit_take ? HIT : inflight == '0 ? IDLE : DRAIN;
      default:   next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_nonce <= '0;
      msg <= '{default: '0};
      nonce_k <= '{default: '0};
      zbits <= '0;
      beat <= '0;
      sel <= '0;
      rr <= '0;
      inflight <= '0;
      seen_busy <= '0;
      stop_pend <= 1'b0;
      bus.hit <= 1'b0;
      bus.hit_nonce <= '0;
      bus.nonce_cur <= '0;
      bus.wrapped <= 1'b0;
    end else begin
      seen_busy <= (seen_busy | (inflight & bus.core_busy)) & ~done;
      inflight <= inflight & ~done;
      beat <= state == LOAD && next == LOAD ? beat + 5'd1 : 5'd0;
      stop_pend <= state == LOAD && (stop_pend || stop);
      if (cfg_ok && bus.cfg_we) begin
        if (bus.cfg_addr == 5'd0) start_nonce <= bus.cfg_wdata;
        else if (bus.cfg_addr < 5'd16) msg[bus.cfg_addr[3:0]] <= bus.cfg_wdata;
        else if (bus.cfg_addr == 5'd16) zbits <= bus.cfg_wdata > 32 ? 6'd32 : bus.cfg_wdata[5:0];
      end
      if (cfg_ok && go) begin
        bus.hit <= 1'b0;
        bus.wrapped <= 1'b0;
        bus.nonce_cur <= start_nonce;
        inflight <= '0;
        seen_busy <= '0;
        rr <= '0;
      end
      if (hit_take) begin
        bus.hit <= 1'b1;
        bus.hit_nonce <= win_nonce;
      end
      if (state == SELECT && next == LOAD) begin
        sel <= pick;
        rr <= pick == IW'(NUM_CORES - 1) ? '0 : pick + 1'b1;
      end
      if (load_end && !hit_take) begin
        nonce_k[sel] <= bus.nonce_cur;
        inflight[sel] <= 1'b1;
        bus.nonce_cur <= bus.nonce_cur + 32'd1;
        if (bus.nonce_cur == 32'hFFFFFFFF) bus.wrapped <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sha_dispatch_sched.sv
// tb_sha_dispatch_sched: directed bench with a two-core behavioural sha256 model
module tb_sha_dispatch_sched;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  sha_dispatch_sched_if #(.NUM_CORES(2)) bus ();
  sha_dispatch_sched #(.NUM_CORES(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  int vectors = 0;
  int miscompares = 0;
  int disp = 0;
  int mode = 0;
  logic hold = 1'b0;
  int ph [2];
  int bt [2];
  int cnt [2];
  logic [31:0] mn [2];
  logic [31:0] mdig [2];
  logic [1:0] mbusy;
  assign bus.core_busy = mbusy;
  assign bus.core_dig_hi = {mdig[1], mdig[0]};
  function automatic logic [31:0] dig_of(input logic [31:0] n);
    return mode == 0 ? 32'h01234567 :
           mode == 1 ? (n == 32'h105 ? 32'h00ABCDEF : 32'h01ABCDEF) : 32'hFFFFFFFF;
  endfunction
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mbusy <= '0;
      for (int k = 0; k < 2; k++) begin
        ph[k] <= 0; bt[k] <= 0; cnt[k] <= 0; mn[k] <= '0; mdig[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (ph[k] == 0) begin
          if (bus.core_cmd_w[k]) begin ph[k] <= 1; bt[k] <= 0; end
        end else if (ph[k] == 1) begin
          if (bt[k] == 0) mn[k] <= bus.core_text;
          if (bt[k] == 15) begin ph[k] <= 2; mbusy[k] <= 1'b1; cnt[k] <= 4; end
          else bt[k] <= bt[k] + 1;
        end else begin
          if (cnt[k] > 0) cnt[k] <= cnt[k] - 1;
          else if (!hold) begin mbusy[k] <= 1'b0; mdig[k] <= dig_of(mn[k]); ph[k] <= 0; end
        end
      end
    end
  end
  always @(posedge clk) if (|bus.core_cmd_w) disp++;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hold = 1'b0;
    disp = 0;
    @(negedge clk);
  endtask
  task automatic wait_hit(input string tag, input int maxc);
    int n = 0;
    while (!bus.hit && n < maxc) begin @(negedge clk); n++; end
    check(tag, 32'(bus.hit), 32'd1);
  endtask
  initial begin
    int d;
    int n;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_hit", 32'(bus.hit), 0);
    check("rst_hit_nonce", bus.hit_nonce, 0);
    check("rst_nonce_cur", bus.nonce_cur, 0);
    check("rst_wrapped", 32'(bus.wrapped), 0);
    check("rst_text", bus.core_text, 0);
    check("rst_cmd", 32'(bus.core_cmd), 0);
    check("rst_cmd_w", 32'(bus.core_cmd_w), 0);
    reset = 1'b0;
    @(negedge clk);
    // basic dispatch, zbits=0: every digest qualifies
    wr(5'd0, 32'h100);
    for (int i = 1; i < 16; i++) wr(5'(i), 32'h1000 + i);
    wr(5'd17, 32'd1);
    check("sel_busy", 32'(bus.busy), 1);
    check("sel_cmd_w", 32'(bus.core_cmd_w), 0);
    cyc(1);
    check("hdr_cmd_w", 32'(bus.core_cmd_w), 1);
    check("hdr_cmd", 32'(bus.core_cmd), 32'd2);
    for (int b = 1; b <= 16; b++) begin
      cyc(1);
      check($sformatf("text_beat%0d", b), bus.core_text, b == 1 ? 32'h100 : 32'h1000 + b - 1);
    end
    wait_hit("hit1", 100);
    check("hit_nonce1", bus.hit_nonce, 32'h100);
    check("hit1_idle", 32'(bus.busy), 0);
    // zbits=8, only nonce 0x105 qualifies
    do_reset();
    mode = 1;
    wr(5'd0, 32'h100);
    wr(5'd16, 32'd8);
    wr(5'd17, 32'd1);
    wait_hit("hit2", 400);
    check("hit_nonce2", bus.hit_nonce, 32'h105);
    d = disp;
    cyc(60);
    check("no_dispatch_in_hit", disp, d);
    check("nonce_cur_bound", 32'(bus.nonce_cur <= 32'h107), 1);
    // wrap from 0xFFFFFFFF; zbits=64 saturates to 32 so nothing qualifies
    do_reset();
    mode = 2;
    wr(5'd0, 32'hFFFFFFFF);
    wr(5'd16, 32'd64);
    wr(5'd17, 32'd1);
    check("wrap_before", 32'(bus.wrapped), 0);
    check("nonce_start", bus.nonce_cur, 32'hFFFFFFFF);
    cyc(18);
    check("wrap_after", 32'(bus.wrapped), 1);
    check("nonce_wrapped", bus.nonce_cur, 0);
    cyc(1);
    check("second_cmd_w", 32'(bus.core_cmd_w), 32'd2);
    cyc(1);
    check("second_nonce", bus.core_text, 0);
    cyc(60);
    check("zbits_saturate", 32'(bus.hit), 0);
    // simultaneous qualifying completions: lowest core wins
    do_reset();
    mode = 0;
    hold = 1'b1;
    wr(5'd0, 32'h20);
    wr(5'd17, 32'd1);
    cyc(60);
    check("hold_no_hit", 32'(bus.hit), 0);
    check("hold_busy", 32'(bus.busy), 1);
    hold = 1'b0;
    wait_hit("hit4", 40);
    check("hit_nonce_tie", bus.hit_nonce, 32'h20);
    // stop mid-LOAD, drain, and cfg write dropped while draining
    do_reset();
    mode = 2;
    wr(5'd16, 32'd32);
    wr(5'd5, 32'h5555);
    wr(5'd0, 32'h40);
    disp = 0;
    wr(5'd17, 32'd1);
    cyc(5);
    wr(5'd17, 32'd2);
    check("stop_busy", 32'(bus.busy), 1);
    cyc(12);
    check("stop_load_done", bus.nonce_cur, 32'h41);
    check("drain_busy", 32'(bus.busy), 1);
    wr(5'd5, 32'hDEAD);
    n = 0;
    while (bus.busy && n < 50) begin @(negedge clk); n++; end
    check("drain_idle", 32'(bus.busy), 0);
    check("drain_no_hit", 32'(bus.hit), 0);
    check("drain_dispatches", disp, 1);
    mode = 0;
    wr(5'd16, 32'd0);
    wr(5'd17, 32'd1);
    cyc(2);
    check("restart_nonce", bus.core_text, 32'h40);
    cyc(5);
    check("w5_kept", bus.core_text, 32'h5555);
    // asynchronous reset during LOAD beat 7
    do_reset();
    wr(5'd0, 32'h77);
    wr(5'd17, 32'd1);
    cyc(8);
    check("pre_rst_nonce", bus.nonce_cur, 32'h77);
    reset = 1'b1;
    #1;
    check("async_cmd_w", 32'(bus.core_cmd_w), 0);
    check("async_busy", 32'(bus.busy), 0);
    check("async_nonce", bus.nonce_cur, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    wr(5'd17, 32'd1);
    cyc(1);
    check("post_rst_cmd_w", 32'(bus.core_cmd_w), 1);
    cyc(1);
    check("post_rst_text", bus.core_text, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
